// File: rtl/wb_mux_pkg.sv
// Shared types for the 4-master Wishbone request mux.
// Owner index width and mux FSM encoding.
package wb_mux_pkg;

  localparam int NMST  = 4;
  localparam int OWN_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } wbm_state_t;

endpackage

// File: rtl/wb_master_mux.sv
// 4-master to 1-slave Wishbone mux with owner latch,
// registered slave request and timeout termination.
module wb_master_mux
  import wb_mux_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TMO_CYC = 255,
  parameter int TMO_W   = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NMST-1:0]      m_cyc_i,
  input  logic [NMST-1:0]      m_stb_i,
  input  logic [NMST-1:0]      m_we_i,
  input  logic [NMST*AW-1:0]   m_adr_i,
  input  logic [NMST*DW-1:0]   m_wdata_i,
  input  logic [NMST*DW/8-1:0] m_sel_i,
  output logic [NMST-1:0]      m_ack_o,
  output logic [NMST-1:0]      m_err_o,
  output logic [DW-1:0]        m_rdata_o,
  output logic [NMST-1:0]      arb_req_o,
  input  logic [OWN_W-1:0]     arb_gnt_i,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_wdata_o,
  output logic [DW/8-1:0]      s_sel_o,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  input  logic [DW-1:0]        s_rdata_i
);

  localparam int SW = DW / 8;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TMO_CYC - 1);

  wbm_state_t        state_q, state_d;
  logic [OWN_W-1:0]  owner_q, owner_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              s_cyc_q, s_cyc_d;
  logic              s_we_q, s_we_d;
  logic [AW-1:0]     s_adr_q, s_adr_d;
  logic [DW-1:0]     s_wdata_q, s_wdata_d;
  logic [SW-1:0]     s_sel_q, s_sel_d;
  logic [NMST-1:0]   ack_q, ack_d;
  logic [NMST-1:0]   err_q, err_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  int                gi;

  assign arb_req_o = m_cyc_i & m_stb_i;
  assign gi        = int'(arb_gnt_i);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    tmo_d     = tmo_q;
    s_cyc_d   = s_cyc_q;
    s_we_d    = s_we_q;
    s_adr_d   = s_adr_q;
    s_wdata_d = s_wdata_q;
    s_sel_d   = s_sel_q;
    ack_d     = '0;
    err_d     = '0;
    rdata_d   = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (arb_req_o[arb_gnt_i]) begin
          owner_d   = arb_gnt_i;
          s_we_d    = m_we_i[arb_gnt_i];
          s_adr_d   = m_adr_i[gi*AW +: AW];
          s_wdata_d = m_wdata_i[gi*DW +: DW];
          s_sel_d   = m_sel_i[gi*SW +: SW];
          s_cyc_d   = 1'b1;
          tmo_d     = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // Abort beats any response; err beats ack; ack beats timeout.
        if (!m_cyc_i[owner_q]) begin
          s_cyc_d = 1'b0;
          state_d = IDLE;
        end else if (s_err_i) begin
          s_cyc_d         = 1'b0;
          err_d[owner_q]  = 1'b1;
          state_d         = DONE;
        end else if (s_ack_i) begin
          s_cyc_d         = 1'b0;
          ack_d[owner_q]  = 1'b1;
          rdata_d         = s_rdata_i;
          state_d         = DONE;
        end else if (tmo_q == TMO_LAST) begin
          s_cyc_d         = 1'b0;
          err_d[owner_q]  = 1'b1;
          state_d         = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      tmo_q     <= '0;
      s_cyc_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_adr_q   <= '0;
      s_wdata_q <= '0;
      s_sel_q   <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      tmo_q     <= tmo_d;
      s_cyc_q   <= s_cyc_d;
      s_we_q    <= s_we_d;
      s_adr_q   <= s_adr_d;
      s_wdata_q <= s_wdata_d;
      s_sel_q   <= s_sel_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_cyc_o   = s_cyc_q;
  assign s_stb_o   = s_cyc_q;
  assign s_we_o    = s_we_q;
  assign s_adr_o   = s_adr_q;
  assign s_wdata_o = s_wdata_q;
  assign s_sel_o   = s_sel_q;
  assign m_ack_o   = ack_q;
  assign m_err_o   = err_q;
  assign m_rdata_o = rdata_q;

endmodule
